// File: rtl/input_port_ctrl.sv
// rtl/input_port_ctrl.sv - wormhole input port controller with XY route and switch request
// Purpose : sits after the input flit buffer. Routes the head flit (XY), requests the switch
//           allocator, then streams the packet through to the crossbar until its tail.
// Ports   : clk, rst (sync, active-high)
//           flit_i/empty_i/pop_o   buffer read side (pop_o combinational)
//           req_o/grant_i          one-hot allocator request/grant [0]L [1]N [2]E [3]S [4]W
//           out_on_i               downstream on/off flow control
//           flit_o/flit_valid_o    registered crossbar output
//           drop_o                 1-cycle pulse when a stray non-head flit is discarded
// Option  : IPC_STATS_EN adds pkt_cnt_o / flit_cnt_o packet and flit counters.
module input_port_ctrl #(
  parameter int COORD_W = 4,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] flit_i,
  input  logic        empty_i,
  output logic        pop_o,
  output logic [4:0]  req_o,
  input  logic [4:0]  grant_i,
  input  logic        out_on_i,
  output logic [63:0] flit_o,
  output logic        flit_valid_o,
`ifdef IPC_STATS_EN
  output logic        drop_o,
  output logic [15:0] pkt_cnt_o,
  output logic [15:0] flit_cnt_o
`else
  output logic        drop_o
`endif
);

  localparam logic [COORD_W-1:0] LX = COORD_W'(LOCAL_X);
  localparam logic [COORD_W-1:0] LY = COORD_W'(LOCAL_Y);

  localparam logic [4:0] PORT_L = 5'b00001;
  localparam logic [4:0] PORT_N = 5'b00010;
  localparam logic [4:0] PORT_E = 5'b00100;
  localparam logic [4:0] PORT_S = 5'b01000;
  localparam logic [4:0] PORT_W = 5'b10000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  route_q, route_d;
  logic [63:0] flit_q, flit_d;
  logic        flit_valid_q, flit_valid_d;
  logic        drop_q, drop_d;
  logic        pop;
  logic        granted;
  logic        pop_active;

  // Type field [63:62]: bit 62 marks a head (HEAD/HEAD_TAIL), bit 63 marks a tail (TAIL/HEAD_TAIL).
  function automatic logic [4:0] xy_route(input logic [COORD_W-1:0] dx,
                                          input logic [COORD_W-1:0] dy);
    logic [4:0] r;
    if (dx > LX)      r = PORT_E;
    else if (dx < LX) r = PORT_W;
    else if (dy > LY) r = PORT_N;
    else if (dy < LY) r = PORT_S;
    else              r = PORT_L;
    return r;
  endfunction

  assign granted = |(grant_i & route_q);

  always_comb begin
    state_d      = state_q;
    route_d      = route_q;
    flit_d       = flit_q;
    flit_valid_d = 1'b0;
    drop_d       = 1'b0;
    pop          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_i) begin
          if (flit_i[62]) begin
            // Head stays in the buffer; it is popped once the grant arrives.
            route_d = xy_route(flit_i[2*COORD_W-1:COORD_W], flit_i[COORD_W-1:0]);
            state_d = S_REQ;
          end else begin
            pop    = 1'b1;
            drop_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (granted) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        pop = ~empty_i & out_on_i & granted;
        if (pop) begin
          flit_d       = flit_i;
          flit_valid_d = 1'b1;
          // Any tail-marked flit ends the packet, including a HEAD_TAIL seen mid-packet.
          if (flit_i[63]) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      route_q      <= '0;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      route_q      <= route_d;
      flit_q       <= flit_d;
      flit_valid_q <= flit_valid_d;
      drop_q       <= drop_d;
    end
  end

  assign pop_active   = pop & (state_q == S_ACTIVE);
  assign pop_o        = pop & ~rst;
  assign req_o        = (state_q == S_IDLE) ? 5'b00000 : route_q;
  assign flit_o       = flit_q;
  assign flit_valid_o = flit_valid_q;
  assign drop_o       = drop_q;

`ifdef IPC_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] flit_cnt_q, flit_cnt_d;

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    flit_cnt_d = flit_cnt_q;
    if (pop_active) begin
      flit_cnt_d = flit_cnt_q + 16'd1;
      if (flit_i[63]) pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      flit_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      flit_cnt_q <= flit_cnt_d;
    end
  end

  assign pkt_cnt_o  = pkt_cnt_q;
  assign flit_cnt_o = flit_cnt_q;
`else
  logic unused_pop_active;
  assign unused_pop_active = pop_active;
`endif

endmodule
